cache_metadata_array: RTL and testbench

Parametrised tag/valid/LRU store for an N-way set-associative cache. It replaces the per-way 64-set metadata arrays and exposes one registered lookup port, one fill port and a sequenced flush engine. Hit/miss, hit way and replacement victim are resolved inside the block. Sits between the cache controller FSM and the data arrays. The controller issues lookups and fills; the block owns all replacement state.

---
 rtl/cache_metadata_array_if.sv | 48 ++++
 rtl/cache_metadata_array.sv | 210 +++++++++++++++++++++
 tb/tb_cache_metadata_array.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_metadata_array_if.sv
// Controller-facing bundle for the cache metadata array: lookup request and
// response, fill port and flush handshake. The controller takes the master
// side, the array takes the slave side.
interface cache_metadata_array_if #(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int TAG_W = 6
);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic [WAY_W-1:0] rsp_victim;

    logic             fill_en;
    logic [SET_W-1:0] fill_set;
    logic [WAY_W-1:0] fill_way;
    logic [TAG_W-1:0] fill_tag;

    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;

    modport master (
        output req_valid, req_set, req_tag,
        output fill_en, fill_set, fill_way, fill_tag,
        output flush_req,
        input  req_ready,
        input  rsp_valid, rsp_hit, rsp_way, rsp_victim,
        input  flush_busy, flush_done
    );

    modport slave (
        input  req_valid, req_set, req_tag,
        input  fill_en, fill_set, fill_way, fill_tag,
        input  flush_req,
        output req_ready,
        output rsp_valid, rsp_hit, rsp_way, rsp_victim,
        output flush_busy, flush_done
    );
endinterface

// File: rtl/cache_metadata_array.sv
// Tag/valid/age store for an N-way set-associative cache. Resolves hit, hit
// way and replacement victim for one registered lookup per cycle, applies
// fills, and owns a sequenced flush that sweeps one set per cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation, lookups and fills accepted
// S_SWEEP | invalidating set[sweep_q] each cycle, lookups/fills blocked
// S_DONE  | one-cycle completion pulse on flush_done, then back to idle
module cache_metadata_array #(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int TAG_W = 6
) (
    input logic                   clk,
    input logic                   rst,
    cache_metadata_array_if.slave bus
);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1;

    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;
    typedef logic [WAYS-1:0][TAG_W-1:0] tag_vec_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Ages are a recency rank per set: 0 is MRU, WAYS-1 is LRU.
    logic [WAYS-1:0] valid_q [SETS];
    tag_vec_t        tag_q   [SETS];
    age_vec_t        age_q   [SETS];

    state_t           state_q;
    logic [SET_W-1:0] sweep_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic [WAY_W-1:0] rsp_way_q;
    logic [WAY_W-1:0] rsp_victim_q;

    // Power-on / post-flush ordering: way i holds age i.
    function automatic age_vec_t init_ages();
        age_vec_t res;
        for (int j = 0; j < WAYS; j++) begin
            res[j] = WAY_W'(j);
        end
        return res;
    endfunction

    // Make way w the MRU; every way that was more recent than w ages by one.
    function automatic age_vec_t touch(input age_vec_t ages, input logic [WAY_W-1:0] w);
        age_vec_t res;
        res = ages;
        for (int j = 0; j < WAYS; j++) begin
            if (WAY_W'(j) == w) begin
                res[j] = '0;
            end else if (ages[j] < ages[w]) begin
                res[j] = ages[j] + WAY_W'(1);
            end
        end
        return res;
    endfunction

    logic [WAYS-1:0]  lk_valid;
    tag_vec_t         lk_tags;
    age_vec_t         lk_ages;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic             lk_inv_found;
    logic [WAY_W-1:0] lk_inv_way;
    logic [WAY_W-1:0] lk_lru_way;
    logic [WAY_W-1:0] lk_victim;

    logic             accept;
    logic             fill_act;
    logic             hit_touch;
    age_vec_t         fill_ages;
    age_vec_t         hit_ages;

    assign lk_valid = valid_q[bus.req_set];
    assign lk_tags  = tag_q[bus.req_set];
    assign lk_ages  = age_q[bus.req_set];

    // Hit detect and victim select; descending scan so the lowest index wins.
    always_comb begin
        lk_hit       = 1'b0;
        lk_way       = '0;
        lk_inv_found = 1'b0;
        lk_inv_way   = '0;
        lk_lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_valid[w] && (lk_tags[w] == bus.req_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!lk_valid[w]) begin
                lk_inv_found = 1'b1;
                lk_inv_way   = WAY_W'(w);
            end
            if (lk_ages[w] == WAY_W'(WAYS - 1)) begin
                lk_lru_way = WAY_W'(w);
            end
        end
        lk_victim = lk_inv_found ? lk_inv_way : lk_lru_way;
    end

    assign accept    = bus.req_valid & ready_q;
    assign fill_act  = bus.fill_en & (state_q == S_IDLE);
    // A fill to the same set owns the recency update; the hit's touch is dropped.
    assign hit_touch = accept & lk_hit & ~(fill_act & (bus.fill_set == bus.req_set));
    assign fill_ages = touch(age_q[bus.fill_set], bus.fill_way);
    assign hit_ages  = touch(lk_ages, lk_way);

    // Metadata storage: flush sweep, fills and hit touches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                tag_q[s]   <= '0;
                age_q[s]   <= init_ages();
            end
        end else if (state_q == S_SWEEP) begin
            valid_q[sweep_q] <= '0;
            age_q[sweep_q]   <= init_ages();
        end else begin
            if (fill_act) begin
                valid_q[bus.fill_set][bus.fill_way] <= 1'b1;
                tag_q[bus.fill_set][bus.fill_way]   <= bus.fill_tag;
                age_q[bus.fill_set]                 <= fill_ages;
            end
            if (hit_touch) begin
                age_q[bus.req_set] <= hit_ages;
            end
        end
    end

    // Flush sequencer with registered ready/busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.flush_req) begin
                        state_q <= S_SWEEP;
                        sweep_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    sweep_q <= sweep_q + SET_W'(1);
                    if (sweep_q == SET_W'(SETS - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    sweep_q <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lookup response register; result fields hold until the next accepted lookup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_victim_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_hit_q    <= lk_hit;
                rsp_way_q    <= lk_way;
                rsp_victim_q <= lk_victim;
            end
        end
    end

    // ready is forced low while reset is asserted so every output reads 0 in reset.
    assign bus.req_ready  = ready_q & rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_way    = rsp_way_q;
    assign bus.rsp_victim = rsp_victim_q;
    assign bus.flush_busy = busy_q;
    assign bus.flush_done = done_q;
endmodule

// File: tb/tb_cache_metadata_array.sv
module tb_cache_metadata_array;
    localparam int SETS  = 64;
    localparam int WAYS  = 4;
    localparam int TAG_W = 6;
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_metadata_array_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

    cache_metadata_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: valid/tag per entry plus a recency list per set
    // (m_order[s][0] is the most recently used way).
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_order [SETS][WAYS];

    bit e_valid;
    bit e_hit;
    int e_way;
    int e_victim;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s][w] = w;
            end
    endtask

    task automatic model_touch(input int s, input int w);
        int p = 0;
        for (int q = 0; q < WAYS; q++)
            if (m_order[s][q] == w) p = q;
        for (int q = p; q > 0; q--)
            m_order[s][q] = m_order[s][q-1];
        m_order[s][0] = w;
    endtask

    task automatic model_lookup(input int s, input int t, output bit hit, output int way, output int victim);
        hit = 1'b0; way = 0; victim = -1;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1; way = w;
            end
        for (int w = 0; w < WAYS; w++)
            if (victim < 0 && !m_valid[s][w]) victim = w;
        if (victim < 0) victim = m_order[s][WAYS-1];
    endtask

    // One clock of stimulus with model update; ends #1 after the edge.
    task automatic op(input bit lv, input int ls, input int lt,
                      input bit fe, input int fs, input int fw, input int ft);
        bit h = 1'b0;
        int w = 0, v = 0;
        bus.req_valid = lv;
        bus.req_set   = SET_W'(ls);
        bus.req_tag   = TAG_W'(lt);
        bus.fill_en   = fe;
        bus.fill_set  = SET_W'(fs);
        bus.fill_way  = WAY_W'(fw);
        bus.fill_tag  = TAG_W'(ft);
        if (lv) begin
            model_lookup(ls, lt, h, w, v);
            e_hit = h; e_way = w; e_victim = v;
        end
        if (fe) begin
            m_valid[fs][fw] = 1'b1;
            m_tag[fs][fw]   = ft;
            model_touch(fs, fw);
        end
        if (lv && h && !(fe && fs == ls)) model_touch(ls, w);
        e_valid = lv;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.fill_en   = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_set = '0; bus.req_tag = '0;
        bus.fill_en = 0; bus.fill_set = '0; bus.fill_way = '0; bus.fill_tag = '0;
        bus.flush_req = 0;
        e_hit = 0; e_way = 0; e_victim = 0; e_valid = 0;
        model_reset();
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, bus.flush_busy, bus.flush_done, bus.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b hit=%b way=%0d victim=%0d busy=%b done=%b ready=%b want all 0",
                     bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, bus.flush_busy, bus.flush_done, bus.req_ready);
        end
        @(posedge clk); @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        op(1, 5, 'h2A, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_victim !== WAY_W'(0) || bus.rsp_way !== WAY_W'(0)) begin
            n_fail++;
            $display("FAIL reset_first_lookup: got valid=%b hit=%b way=%0d victim=%0d want 1 0 0 0",
                     bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim);
        end
        op(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_hit !== 1'b0) begin
            n_fail++; $display("FAIL rsp_pulse: got valid=%b hit=%b want 0 0", bus.rsp_valid, bus.rsp_hit);
        end
    endtask

    task automatic test_fill_hit();
        int lks[4] = '{'h2A, 'h11, 'h2A, 'h33};
        op(0, 0, 0, 1, 5, 0, 'h2A);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) op(0, 0, 0, 1, 5, 1, 'h11);
            op(1, 5, lks[i], 0, 0, 0, 0);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== e_hit || bus.rsp_way !== WAY_W'(e_way) || bus.rsp_victim !== WAY_W'(e_victim)) begin
                n_fail++;
                $display("FAIL fill_hit[%0d]: got valid=%b hit=%b way=%0d victim=%0d want 1 %b %0d %0d",
                         i, bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, e_hit, e_way, e_victim);
            end
        end
    endtask

    task automatic test_lru_order();
        for (int w = 0; w < WAYS; w++) op(0, 0, 0, 1, 9, w, w + 1);
        op(1, 9, 3, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_hit !== 1'b1 || bus.rsp_way !== WAY_W'(2)) begin
            n_fail++; $display("FAIL lru_hit2: got hit=%b way=%0d want 1 2", bus.rsp_hit, bus.rsp_way);
        end
        op(1, 9, 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_hit !== 1'b1 || bus.rsp_way !== WAY_W'(0)) begin
            n_fail++; $display("FAIL lru_hit0: got hit=%b way=%0d want 1 0", bus.rsp_hit, bus.rsp_way);
        end
        for (int i = 0; i < WAYS; i++) begin
            op(1, 9, 'h30 + i, 0, 0, 0, 0);
            n_checks++;
            if (bus.rsp_hit !== 1'b0 || bus.rsp_victim !== WAY_W'(e_victim)) begin
                n_fail++;
                $display("FAIL lru_victim[%0d]: got hit=%b victim=%0d want 0 %0d", i, bus.rsp_hit, bus.rsp_victim, e_victim);
            end
            op(0, 0, 0, 1, 9, e_victim, 'h30 + i);
        end
    endtask

    task automatic test_collision();
        for (int w = 0; w < WAYS; w++) op(0, 0, 0, 1, 3, w, 'h10 + w);
        op(1, 3, 'h10, 1, 3, 1, 'h21);
        n_checks++;
        if (bus.rsp_hit !== 1'b1 || bus.rsp_way !== WAY_W'(0)) begin
            n_fail++; $display("FAIL collision_hit: got hit=%b way=%0d want 1 0", bus.rsp_hit, bus.rsp_way);
        end
        op(1, 3, 'h3E, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_hit !== 1'b0 || bus.rsp_victim !== WAY_W'(e_victim)) begin
            n_fail++; $display("FAIL collision_victim: got hit=%b victim=%0d want 0 %0d", bus.rsp_hit, bus.rsp_victim, e_victim);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 5),
               $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, WAYS - 1), $urandom_range(0, 5));
            n_checks++;
            if (bus.rsp_valid !== e_valid || bus.rsp_hit !== e_hit || bus.rsp_way !== WAY_W'(e_way) || bus.rsp_victim !== WAY_W'(e_victim)) begin
                n_fail++;
                $display("FAIL random[%0d]: got valid=%b hit=%b way=%0d victim=%0d want %b %b %0d %0d",
                         i, bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, e_valid, e_hit, e_way, e_victim);
            end
        end
    endtask

    task automatic test_flush();
        int busy_cycles = 0;
        op(0, 0, 0, 1, 5, 2, 'h07);
        bus.flush_req = 1'b1;
        op(1, 5, 'h07, 0, 0, 0, 0);
        bus.flush_req = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_way !== WAY_W'(2)) begin
            n_fail++; $display("FAIL flush_prehit: got valid=%b hit=%b way=%0d want 1 1 2", bus.rsp_valid, bus.rsp_hit, bus.rsp_way);
        end
        model_reset();
        for (int c = 1; c <= SETS + 2; c++) begin
            if (bus.flush_busy === 1'b1) busy_cycles++;
            n_checks++;
            if (c <= SETS + 1) begin
                if (bus.flush_busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.flush_done !== (c == SETS + 1) || (c > 1 && bus.rsp_valid !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL flush_cycle[%0d]: got busy=%b ready=%b done=%b rspv=%b want 1 0 %b 0",
                             c, bus.flush_busy, bus.req_ready, bus.flush_done, bus.rsp_valid, c == SETS + 1);
                end
            end else begin
                if (bus.flush_busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.flush_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_end: got busy=%b ready=%b done=%b want 0 1 0", bus.flush_busy, bus.req_ready, bus.flush_done);
                end
                break;
            end
            bus.fill_en   = 1'b1;
            bus.fill_set  = SET_W'($urandom_range(0, SETS - 1));
            bus.fill_way  = WAY_W'($urandom_range(0, WAYS - 1));
            bus.fill_tag  = TAG_W'($urandom_range(0, 5));
            bus.req_valid = 1'b1;
            bus.flush_req = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            bus.fill_en = 1'b0; bus.req_valid = 1'b0; bus.flush_req = 1'b0;
        end
        n_checks++;
        if (busy_cycles != SETS + 1) begin
            n_fail++; $display("FAIL flush_busy_len: got %0d want %0d", busy_cycles, SETS + 1);
        end
        for (int i = 0; i < 24; i++) begin
            op(1, (i < 4) ? i : $urandom_range(0, SETS - 1), $urandom_range(0, 5), 0, 0, 0, 0);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== e_hit || bus.rsp_victim !== WAY_W'(e_victim)) begin
                n_fail++;
                $display("FAIL post_flush[%0d]: got valid=%b hit=%b victim=%0d want 1 %b %0d", i, bus.rsp_valid, bus.rsp_hit, bus.rsp_victim, e_hit, e_victim);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int w = 0; w < WAYS; w++) op(0, 0, 0, 1, 7, w, 'h20 + w);
        op(1, 7, 'h20, 0, 0, 0, 0);
        op(1, 7, 'h20 + WAYS - 1, 0, 0, 0, 0);
        n_checks++;
        if (bus.rsp_hit !== 1'b1 || bus.rsp_way !== WAY_W'(e_way) || bus.rsp_victim !== WAY_W'(e_victim)) begin
            n_fail++; $display("FAIL premid_lookup: got hit=%b way=%0d victim=%0d want 1 %0d %0d", bus.rsp_hit, bus.rsp_way, bus.rsp_victim, e_way, e_victim);
        end
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, bus.flush_busy, bus.flush_done, bus.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL midsweep_reset: got valid=%b hit=%b way=%0d victim=%0d busy=%b done=%b ready=%b want all 0",
                     bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim, bus.flush_busy, bus.flush_done, bus.req_ready);
        end
        model_reset();
        e_hit = 0; e_way = 0; e_victim = 0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL midsweep_release: got ready=%b busy=%b want 1 0", bus.req_ready, bus.flush_busy);
        end
        for (int i = 0; i < 24; i++) begin
            op(1, (i == 0) ? 7 : $urandom_range(0, SETS - 1), (i == 0) ? 'h20 : $urandom_range(0, 63), 0, 0, 0, 0);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== e_hit || bus.rsp_victim !== WAY_W'(e_victim)) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got valid=%b hit=%b victim=%0d want 1 %b %0d", i, bus.rsp_valid, bus.rsp_hit, bus.rsp_victim, e_hit, e_victim);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_hit();
        test_lru_order();
        test_collision();
        test_back_to_back();
        test_flush();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
